jt89_wr_fifo: RTL and testbench
===============================

JT89_WR_FIFO -- requirements
Module: jt89_wr_fifo

Interface
REQ-001 SHALL have parameter AW, default 3, meaning log2 of FIFO depth (8 entries).
REQ-002 SHALL have parameter GAP, default 2, meaning idle clocks forced between consecutive PSG strobes (range 0-15).
REQ-003 SHALL have port clk, input, 1, meaning system clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port cpu_wr, input, 1, meaning a one-cycle CPU write strobe to the PSG port.
REQ-006 SHALL have port cpu_din, input, 8, meaning the CPU data byte, sampled when cpu_wr=1.
REQ-007 SHALL have port psg_ready, input, 1, meaning the downstream PSG can accept a write.
REQ-008 SHALL have port psg_wr_n, output, 1, meaning the active-low write strobe to the PSG.
REQ-009 SHALL have port psg_din, output, 8, meaning the data byte to the PSG, stable whenever psg_wr_n=0.
REQ-010 SHALL have port full, output, 1, meaning level equals 2^AW.
REQ-011 SHALL have port empty, output, 1, meaning level equals 0.
REQ-012 SHALL have port level, output, AW+1, meaning the current FIFO occupancy.
REQ-013 SHALL have port overflow, output, 1, meaning a sticky flag set when a write is dropped.

Function
REQ-014 SHALL push cpu_din on a rising edge where cpu_wr=1 and full=0.
REQ-015 SHALL drop a write that arrives while full=1, even if a pop occurs in the same cycle, and SHALL leave level and stored data unchanged.
REQ-016 SHALL apply a simultaneous push and pop in the same cycle, with level unchanged and FIFO order preserved.
REQ-017 SHALL implement a circular buffer whose read and write pointers wrap modulo 2^AW, with level in the range 0 to 2^AW.
REQ-018 SHALL run an issue FSM with three states: IDLE, STROBE and GAPW.
REQ-019 In IDLE with empty=0 and psg_ready=1, the FSM SHALL load psg_din with the head byte, pop it, and go to STROBE.
REQ-020 In IDLE when empty=1 or psg_ready=0, the FSM SHALL stay in IDLE.
REQ-021 In STROBE, psg_wr_n SHALL be 0 for exactly one cycle; the FSM then goes to GAPW, or to IDLE when GAP=0.
REQ-022 In GAPW, the FSM SHALL count GAP cycles and then return to IDLE; psg_ready is ignored during GAPW.
REQ-023 psg_wr_n SHALL be 1 in every state other than STROBE.
REQ-024 psg_din SHALL hold its last value outside STROBE.
REQ-025 Latency: with cpu_wr high in cycle N, the FIFO empty, the FSM in IDLE and psg_ready=1, psg_wr_n SHALL be 0 in cycle N+2.
REQ-026 Back-to-back strobes SHALL be spaced GAP+2 cycles apart when psg_ready stays 1.
REQ-027 full, empty and level SHALL be registered and SHALL reflect the state after each edge.
REQ-028 If psg_ready falls while in STROBE, the strobe SHALL still complete; the byte is considered delivered.

Reset
REQ-029 While rst=1, the block SHALL hold: pointers=0, level=0, empty=1, full=0, overflow=0, psg_wr_n=1, psg_din=0, FSM=IDLE, gap counter=0.
REQ-030 Asserting rst mid-strobe SHALL immediately force psg_wr_n to 1 and discard all queued bytes.
REQ-031 FIFO storage contents need not be reset.

Configuration
REQ-032 With macro JT89_WR_FIFO_OVF_EN defined, overflow SHALL be set on any dropped write and cleared only by rst.
REQ-033 Without JT89_WR_FIFO_OVF_EN, overflow SHALL be tied to 0 and no overflow register SHALL exist.
REQ-034 The drop behaviour of REQ-015 SHALL be identical with or without the macro.

Verification
REQ-035 Single write: write 0x9F into an empty FIFO with psg_ready=1 -> psg_wr_n=0 in cycle N+2 with psg_din=0x9F, then level=0 and empty=1.
REQ-036 Burst: 4 writes 0x80,0x05,0x90,0x0F on consecutive cycles, GAP=2 -> four strobes 4 cycles apart, in the same order.
REQ-037 Overflow (with macro): hold psg_ready=0 and write 9 bytes, AW=3 -> full=1, level=8, overflow=1; release psg_ready -> only the first 8 bytes are emitted.
REQ-038 Backpressure: psg_ready=0 with 2 bytes queued -> psg_wr_n stays 1; psg_ready=1 -> emission resumes within 1 cycle.
REQ-039 Simultaneous events: push while popping at level=3 -> level stays 3; push at full with a pop in the same cycle -> the write is dropped and level becomes 7.
REQ-040 Reset: assert rst during STROBE with 5 bytes queued -> psg_wr_n=1 asynchronously, level=0, empty=1, overflow=0.

Source files
------------

// File: rtl/jt89_wr_fifo.sv
//==============================================================================
// Module   : jt89_wr_fifo
// Brief    : CPU-to-PSG write FIFO with a paced strobe issuer.
//            Optional macro JT89_WR_FIFO_OVF_EN adds a sticky overflow flag.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module jt89_wr_fifo #(
   parameter int AW  = 3,
   parameter int GAP = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_wr,
   input  logic [7:0]    cpu_din,
   input  logic          psg_ready,
   output logic          psg_wr_n,
   output logic [7:0]    psg_din,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          overflow
);

   localparam int            c_depth    = 1 << AW;
   localparam logic [AW:0]   c_full_lvl = c_depth[AW:0];
   localparam logic [AW:0]   c_lvl_one  = 1;
   localparam logic [AW-1:0] c_ptr_one  = 1;
   localparam bit            c_has_gap  = (GAP > 0);
   localparam logic [3:0]    c_gap_last = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STROBE = 2'd1,
      S_GAPW   = 2'd2
   } state_t;

   logic [7:0]    r_mem [c_depth];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic [AW:0]   w_level_nxt;
   logic          r_full;
   logic          r_empty;
   logic          r_psg_wr_n;
   logic [7:0]    r_psg_din;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_gap_cnt;
   logic [3:0]    w_gap_cnt_nxt;
   logic          w_push;
   logic          w_pop;

   // A write seen while full is dropped even if a pop frees a slot this cycle
   assign w_push = cpu_wr & ~r_full;

   always_comb begin
      w_state_nxt   = r_state;
      w_gap_cnt_nxt = r_gap_cnt;
      w_pop         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_empty && psg_ready) begin
               w_pop       = 1'b1;
               w_state_nxt = S_STROBE;
            end
         end
         S_STROBE: begin
            w_gap_cnt_nxt = 4'd0;
            w_state_nxt   = c_has_gap ? S_GAPW : S_IDLE;
         end
         S_GAPW: begin
            if (r_gap_cnt == c_gap_last) begin
               w_gap_cnt_nxt = 4'd0;
               w_state_nxt   = S_IDLE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + c_lvl_one;
         2'b01:   w_level_nxt = r_level - c_lvl_one;
         default: w_level_nxt = r_level;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_state    <= S_IDLE;
         r_gap_cnt  <= 4'd0;
         r_psg_wr_n <= 1'b1;
         r_psg_din  <= 8'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + c_ptr_one;
            r_psg_din <= r_mem[r_rd_ptr];
         end
         r_level    <= w_level_nxt;
         r_full     <= (w_level_nxt == c_full_lvl);
         r_empty    <= (w_level_nxt == '0);
         r_state    <= w_state_nxt;
         r_gap_cnt  <= w_gap_cnt_nxt;
         // Registered strobe keeps psg_wr_n glitch-free
         r_psg_wr_n <= (w_state_nxt != S_STROBE);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= cpu_din;
   end

`ifdef JT89_WR_FIFO_OVF_EN
   logic r_overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_overflow <= 1'b0;
      else if (cpu_wr && r_full) r_overflow <= 1'b1;
   end

   assign overflow = r_overflow;
`else
   assign overflow = 1'b0;
`endif

   assign psg_wr_n = r_psg_wr_n;
   assign psg_din  = r_psg_din;
   assign full     = r_full;
   assign empty    = r_empty;
   assign level    = r_level;

endmodule

`default_nettype wire

// File: tb/tb_jt89_wr_fifo.sv
//==============================================================================
// Module   : tb_jt89_wr_fifo
// Brief    : Scoreboard bench for jt89_wr_fifo (AW=3, GAP=2).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_jt89_wr_fifo;

   localparam int AW  = 3;
   localparam int GAP = 2;
`ifdef JT89_WR_FIFO_OVF_EN
   localparam logic c_ovf_exp = 1'b1;
`else
   localparam logic c_ovf_exp = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_wr = 1'b0;
   logic [7:0]    cpu_din = 8'd0;
   logic          psg_ready = 1'b0;
   logic          psg_wr_n;
   logic [7:0]    psg_din;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic          overflow;

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   logic [7:0]    exp_q[$];
   int            strobe_q[$];

   jt89_wr_fifo #(.AW(AW), .GAP(GAP)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_wr    (cpu_wr),
      .cpu_din   (cpu_din),
      .psg_ready (psg_ready),
      .psg_wr_n  (psg_wr_n),
      .psg_din   (psg_din),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Every strobe pops the oldest expected byte
   always @(posedge clk) begin
      #1;
      if (!rst && psg_wr_n === 1'b0) begin
         strobe_q.push_back(cyc);
         if (exp_q.size() == 0) check("unexpected_strobe", {24'd0, psg_din}, 32'hFFFF_FFFF);
         else                   check("psg_din", {24'd0, psg_din}, {24'd0, exp_q.pop_front()});
      end
   end

   // Called at a negedge; leaves cpu_wr low at the following negedge
   task automatic wr(input logic [7:0] d, input bit kept);
      cpu_wr  = 1'b1;
      cpu_din = d;
      if (kept) exp_q.push_back(d);
      @(negedge clk);
      cpu_wr  = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int b = budget;
      while (exp_q.size() > 0 && b > 0) begin
         @(negedge clk);
         b--;
      end
      check("drain_remaining", exp_q.size(), 0);
      repeat (GAP + 2) @(negedge clk);
   endtask

   initial begin
      int wr_cyc;
      int r_cyc;
      logic [7:0] burst [4];
      burst[0] = 8'h80; burst[1] = 8'h05; burst[2] = 8'h90; burst[3] = 8'h0F;

      repeat (3) @(negedge clk);
      check("rst_level",    level, 0);
      check("rst_empty",    empty, 1);
      check("rst_full",     full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_wr_n",     psg_wr_n, 1);
      check("rst_din",      psg_din, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single write: strobe two cycles after the write cycle
      psg_ready = 1'b1;
      strobe_q.delete();
      wr_cyc = cyc;
      wr(8'h9F, 1);
      wait_drain(20);
      check("single_strobes", strobe_q.size(), 1);
      if (strobe_q.size() > 0) check("single_latency", strobe_q[0] - wr_cyc, 2);
      check("single_level", level, 0);
      check("single_empty", empty, 1);
      check("single_wr_n_idle", psg_wr_n, 1);
      check("single_din_hold", psg_din, 8'h9F);

      // Burst: strobes GAP+2 apart
      strobe_q.delete();
      for (int i = 0; i < 4; i++) wr(burst[i], 1);
      wait_drain(40);
      check("burst_strobes", strobe_q.size(), 4);
      for (int i = 1; i < 4; i++)
         if (strobe_q.size() > i) check("burst_spacing", strobe_q[i] - strobe_q[i-1], GAP + 2);

      // Backpressure
      psg_ready = 1'b0;
      strobe_q.delete();
      wr(8'h11, 1);
      wr(8'h22, 1);
      repeat (5) @(negedge clk);
      check("bp_no_strobe", strobe_q.size(), 0);
      check("bp_level", level, 2);
      r_cyc = cyc;
      psg_ready = 1'b1;
      wait_drain(20);
      check("bp_strobes", strobe_q.size(), 2);
      if (strobe_q.size() > 0) check("bp_resume", strobe_q[0] - r_cyc, 1);

      // Overflow: 9 writes into 8 slots
      psg_ready = 1'b0;
      for (int i = 0; i < 9; i++) wr(8'hA0 + 8'(i), i < 8);
      check("ovf_full",     full, 1);
      check("ovf_level",    level, 8);
      check("ovf_overflow", overflow, c_ovf_exp);
      psg_ready = 1'b1;
      wait_drain(60);
      check("ovf_empty", empty, 1);

      // Simultaneous push/pop at level 3, then drop at full with a pop
      psg_ready = 1'b0;
      wr(8'h31, 1);
      wr(8'h32, 1);
      wr(8'h33, 1);
      psg_ready = 1'b1;
      wr(8'h34, 1);
      psg_ready = 1'b0;
      check("simul_level", level, 3);
      for (int i = 0; i < 5; i++) wr(8'h40 + 8'(i), 1);
      check("simul_full", full, 1);
      psg_ready = 1'b1;
      wr(8'hEE, 0);
      check("drop_level", level, 7);
      check("drop_full", full, 0);
      check("drop_overflow", overflow, c_ovf_exp);
      wait_drain(60);

      // Asynchronous reset mid-strobe with 5 bytes queued
      psg_ready = 1'b0;
      for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i), 1);
      psg_ready = 1'b1;
      @(posedge clk);
      #2;
      check("pre_rst_wr_n", psg_wr_n, 0);
      check("pre_rst_level", level, 4);
      rst = 1'b1;
      #1;
      check("rst_async_wr_n", psg_wr_n, 1);
      check("rst_async_level", level, 0);
      check("rst_async_empty", empty, 1);
      check("rst_async_ovf", overflow, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      strobe_q.delete();
      repeat (6) @(negedge clk);
      check("post_rst_no_strobe", strobe_q.size(), 0);
      check("post_rst_empty", empty, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
